// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, ALU codes, FSM states and control bundle for the multicycle controller
package multicycle_control_pkg;

    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_RTYPE = 6'b100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOT = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_ROL = 4'b1100;
    localparam logic [3:0] ALU_ROR = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6
    } state_t;

    typedef struct packed {
        logic is_rtype;
        logic is_imm;
        logic is_load;
        logic is_store;
        logic is_byte;
        logic is_branch;
        logic is_illegal;
    } instr_class_t;

    typedef struct packed {
        logic       ir_ld_en;
        logic       pc_ld_en;
        logic       pc_sel;
        logic       rf_bsel;
        logic       rf_wr_en;
        logic       rf_wr_data_sel;
        logic       alu_ain_zero;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_req;
        logic       mem_wr_en;
        logic       byte_op;
        logic       illegal_op;
        logic       mem_err;
    } ctrl_t;

    function automatic logic alu_func_legal(input logic [3:0] func);
        case (func)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - datapath/memory control bundle between controller (master) and datapath (slave)
interface multicycle_control_if;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        MEM_Ack;
    logic        IR_LdEn;
    logic        PC_LdEn;
    logic        PC_sel;
    logic        RF_Bsel;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        ALU_Ain_zero;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_Req;
    logic        MEM_WrEn;
    logic        Byte_op;
    logic        Illegal_op;
    logic        Mem_err;

    modport master (
        input  Instr, ALU_zero, MEM_Ack,
        output IR_LdEn, PC_LdEn, PC_sel, RF_Bsel, RF_WrEn, RF_WrData_sel,
               ALU_Ain_zero, ALU_Bin_sel, ALU_func, MEM_Req, MEM_WrEn,
               Byte_op, Illegal_op, Mem_err
    );

    modport slave (
        output Instr, ALU_zero, MEM_Ack,
        input  IR_LdEn, PC_LdEn, PC_sel, RF_Bsel, RF_WrEn, RF_WrData_sel,
               ALU_Ain_zero, ALU_Bin_sel, ALU_func, MEM_Req, MEM_WrEn,
               Byte_op, Illegal_op, Mem_err
    );
endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// rtl/multicycle_control_instr_class_decode.sv - combinational instruction classification from opcode and func
module multicycle_control_instr_class_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [3:0]   func,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                cls.is_rtype   = 1'b1;
                // An unknown ALU func is rejected here so the instruction never reaches EXEC.
                cls.is_illegal = !alu_func_legal(func);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LI, OP_LUI: cls.is_imm = 1'b1;
            OP_LW: cls.is_load = 1'b1;
            OP_LB: begin
                cls.is_load = 1'b1;
                cls.is_byte = 1'b1;
            end
            OP_SW: cls.is_store = 1'b1;
            OP_SB: begin
                cls.is_store = 1'b1;
                cls.is_byte  = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_B: cls.is_branch = 1'b1;
            default: cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with data-memory req/ack handshake and timeout
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    multicycle_control_if.master bus
);

    localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    instr_class_t      cls;
    ctrl_t             ctrl;

    logic [5:0]        opcode;
    logic [3:0]        func;
    logic              uses_rt;
    logic              ain_zero;
    logic [3:0]        alu_op;
    logic              timed_out;
    logic              branch_taken;

    assign opcode = bus.Instr[31:26];
    assign func   = bus.Instr[3:0];

    multicycle_control_instr_class_decode u_class (
        .opcode (opcode),
        .func   (func),
        .cls    (cls)
    );

    assign uses_rt      = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                          (opcode == OP_SB)  || (opcode == OP_SW);
    assign ain_zero     = (opcode == OP_LI) || (opcode == OP_LUI);
    assign timed_out    = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign branch_taken = (opcode == OP_B) ||
                          ((opcode == OP_BEQ) && bus.ALU_zero) ||
                          ((opcode == OP_BNE) && !bus.ALU_zero);

    always_comb begin
        alu_op = ALU_ADD;
        if (cls.is_rtype)            alu_op = func;
        else if (opcode == OP_ANDI)  alu_op = ALU_AND;
        else if (opcode == OP_ORI)   alu_op = ALU_OR;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (cls.is_illegal)      state_d = ST_FETCH;
                else if (cls.is_branch)  state_d = ST_BRANCH;
                else                     state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = (cls.is_load || cls.is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // An ack landing on the last allowed cycle beats the timeout.
                if (bus.MEM_Ack)         state_d = cls.is_load ? ST_WB : ST_FETCH;
                else if (timed_out)      state_d = ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counter runs only while staying in MEM, so every MEM entry starts from zero.
    assign cnt_d = ((state_q == ST_MEM) && (state_d == ST_MEM)) ? cnt_q + CNT_W'(1) : '0;

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: ctrl.ir_ld_en = 1'b1;
            ST_DECODE: begin
                ctrl.rf_bsel = uses_rt;
                if (cls.is_illegal) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.pc_ld_en   = 1'b1;
                end
            end
            ST_EXEC: begin
                ctrl.rf_bsel      = uses_rt;
                ctrl.alu_func     = alu_op;
                ctrl.alu_bin_sel  = !cls.is_rtype;
                ctrl.alu_ain_zero = ain_zero;
            end
            ST_MEM: begin
                ctrl.alu_func     = alu_op;
                ctrl.alu_bin_sel  = !cls.is_rtype;
                ctrl.alu_ain_zero = ain_zero;
                ctrl.mem_req      = 1'b1;
                ctrl.mem_wr_en    = cls.is_store;
                ctrl.byte_op      = cls.is_byte;
                if (bus.MEM_Ack) begin
                    ctrl.pc_ld_en = cls.is_store;
                end else if (timed_out) begin
                    ctrl.mem_err  = 1'b1;
                    ctrl.pc_ld_en = 1'b1;
                end
            end
            ST_WB: begin
                ctrl.alu_func       = alu_op;
                ctrl.alu_bin_sel    = !cls.is_rtype;
                ctrl.alu_ain_zero   = ain_zero;
                ctrl.rf_wr_en       = 1'b1;
                ctrl.rf_wr_data_sel = cls.is_load;
                ctrl.pc_ld_en       = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.rf_bsel     = uses_rt;
                ctrl.alu_func    = ALU_SUB;
                ctrl.alu_bin_sel = 1'b0;
                ctrl.pc_ld_en    = 1'b1;
                ctrl.pc_sel      = branch_taken;
            end
            default: ;
        endcase
    end

    assign bus.IR_LdEn       = ctrl.ir_ld_en;
    assign bus.PC_LdEn       = ctrl.pc_ld_en;
    assign bus.PC_sel        = ctrl.pc_sel;
    assign bus.RF_Bsel       = ctrl.rf_bsel;
    assign bus.RF_WrEn       = ctrl.rf_wr_en;
    assign bus.RF_WrData_sel = ctrl.rf_wr_data_sel;
    assign bus.ALU_Ain_zero  = ctrl.alu_ain_zero;
    assign bus.ALU_Bin_sel   = ctrl.alu_bin_sel;
    assign bus.ALU_func      = ctrl.alu_func;
    assign bus.MEM_Req       = ctrl.mem_req;
    assign bus.MEM_WrEn      = ctrl.mem_wr_en;
    assign bus.Byte_op       = ctrl.byte_op;
    assign bus.Illegal_op    = ctrl.illegal_op;
    assign bus.Mem_err       = ctrl.mem_err;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int TMO = 16;

    localparam logic [5:0] T_BEQ = 6'b000000, T_BNE = 6'b000001, T_LB  = 6'b000011;
    localparam logic [5:0] T_SB  = 6'b000111, T_LW  = 6'b001111, T_SW  = 6'b011111;
    localparam logic [5:0] T_ADDI = 6'b110000, T_ANDI = 6'b110010, T_ORI = 6'b110011;
    localparam logic [5:0] T_LI  = 6'b111000, T_LUI = 6'b111001, T_B   = 6'b111111;
    localparam logic [5:0] T_R   = 6'b100000;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       ir;
        logic       pcld;
        logic       pcsel;
        logic       bsel;
        logic       rfwr;
        logic       wrsel;
        logic       ainz;
        logic       binsel;
        logic [3:0] alu;
        logic       req;
        logic       wren;
        logic       byte_;
        logic       ill;
        logic       merr;
    } outv_t;

    typedef struct {
        logic  ack;
        logic  in_mem;
        outv_t exp;
    } cyc_t;

    cyc_t exp_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        int          ack_at;
        int          cycles;
        int          reqs;
        logic        pcsel;
        logic        rfwr;
        logic        wrsel;
        logic        wren;
        logic        byte_;
        logic        ill;
        logic        merr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'hA5A5A, fn};
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.ir = bus.IR_LdEn;       o.pcld = bus.PC_LdEn;   o.pcsel = bus.PC_sel;
        o.bsel = bus.RF_Bsel;     o.rfwr = bus.RF_WrEn;   o.wrsel = bus.RF_WrData_sel;
        o.ainz = bus.ALU_Ain_zero; o.binsel = bus.ALU_Bin_sel; o.alu = bus.ALU_func;
        o.req = bus.MEM_Req;      o.wren = bus.MEM_WrEn;  o.byte_ = bus.Byte_op;
        o.ill = bus.Illegal_op;   o.merr = bus.Mem_err;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic void push(input outv_t v, input logic ack, input logic in_mem);
        cyc_t c;
        c.ack = ack; c.in_mem = in_mem; c.exp = v;
        exp_q.push_back(c);
    endfunction

    // Reference: list the cycles an instruction goes through and what each must show.
    function automatic void model(input logic [31:0] instr, input logic zero, input int ack_at);
        logic [5:0] op;
        logic [3:0] fn;
        logic r, ld, st, br, imm, ill, bsel, acked, tmo;
        outv_t v, alu;
        op = instr[31:26];
        fn = instr[3:0];
        exp_q.delete();
        r    = (op == T_R);
        ld   = (op == T_LB) || (op == T_LW);
        st   = (op == T_SB) || (op == T_SW);
        br   = (op == T_BEQ) || (op == T_BNE) || (op == T_B);
        imm  = (op == T_ADDI) || (op == T_ANDI) || (op == T_ORI) || (op == T_LI) || (op == T_LUI);
        ill  = !(ld || st || br || imm || (r && (fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                                             4'h8, 4'h9, 4'hA, 4'hC, 4'hD})));
        bsel = (op == T_BEQ) || (op == T_BNE) || (op == T_SB) || (op == T_SW);
        alu = '0;
        alu.alu    = r ? fn : (op == T_ANDI) ? 4'b0010 : (op == T_ORI) ? 4'b0011 : 4'b0000;
        alu.binsel = !r;
        alu.ainz   = (op == T_LI) || (op == T_LUI);

        v = '0; v.ir = 1'b1; push(v, 1'b0, 1'b0);
        v = '0; v.bsel = bsel;
        if (ill) begin v.ill = 1'b1; v.pcld = 1'b1; end
        push(v, 1'b0, 1'b0);
        if (ill) return;
        if (br) begin
            v = '0; v.bsel = bsel; v.alu = 4'b0001; v.pcld = 1'b1;
            v.pcsel = (op == T_B) || ((op == T_BEQ) && zero) || ((op == T_BNE) && !zero);
            push(v, 1'b0, 1'b0);
            return;
        end
        v = alu; v.bsel = bsel; push(v, 1'b0, 1'b0);
        if (ld || st) begin
            for (int k = 1; k <= TMO + 4; k++) begin
                acked = (k == ack_at);
                tmo   = (k == TMO) && !acked;
                v = alu; v.req = 1'b1; v.wren = st; v.byte_ = (op == T_LB) || (op == T_SB);
                v.pcld = (acked && st) || tmo;
                v.merr = tmo;
                push(v, acked, 1'b1);
                if (acked || tmo) break;
            end
            if (st || ack_at < 1 || ack_at > TMO) return;
        end
        v = alu; v.rfwr = 1'b1; v.pcld = 1'b1; v.wrsel = ld; push(v, 1'b0, 1'b0);
    endfunction

    task automatic run_model(input string name, input logic [31:0] instr, input logic zero,
                             input int ack_at, input logic spurious);
        model(instr, zero, ack_at);
        foreach (exp_q[i]) begin
            @(negedge Clk);
            bus.Instr    = instr;
            bus.ALU_zero = zero;
            bus.MEM_Ack  = exp_q[i].ack || (spurious && !exp_q[i].in_mem);
            #1;
            check($sformatf("%s op=%b fn=%h cyc%0d", name, instr[31:26], instr[3:0], i),
                  32'(sample()), 32'(exp_q[i].exp));
        end
    endtask

    // Runs one instruction until its closing PC load, acking on the ack_at-th request cycle.
    task automatic measure(input logic [31:0] instr, input logic zero, input int ack_at,
                           output int cyc, output int reqs, output outv_t any, output logic pcsel_last);
        outv_t o;
        int    memk;
        memk = 0; cyc = 0; reqs = 0; any = '0; pcsel_last = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            bus.Instr = instr; bus.ALU_zero = zero; bus.MEM_Ack = 1'b0;
            #1;
            if (bus.MEM_Req) begin
                memk++; reqs++;
                if (memk == ack_at) bus.MEM_Ack = 1'b1;
                #1;
            end
            o   = sample();
            any = any | o;
            cyc++;
            if (o.pcld) begin
                pcsel_last = o.pcsel;
                return;
            end
        end
        cyc = -1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc, reqs;
        outv_t any;
        logic  pcl;
        logic [5:0]  ops[15];
        logic [31:0] rnd;
        logic [5:0]  op;

        tbl.push_back('{"add",     T_R,    6'b110000, 1'b0, 0,  4,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"lw_ack3", T_LW,   6'b000000, 1'b0, 3,  7,  3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"sb_ack1", T_SB,   6'b000000, 1'b0, 1,  4,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{"beq_z1",  T_BEQ,  6'b000000, 1'b1, 0,  3,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"beq_z0",  T_BEQ,  6'b000000, 1'b0, 0,  3,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"bne_z1",  T_BNE,  6'b000000, 1'b1, 0,  3,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"bne_z0",  T_BNE,  6'b000000, 1'b0, 0,  3,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"b",       T_B,    6'b000000, 1'b0, 0,  3,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"sw_tmo",  T_SW,   6'b000000, 1'b0, 0,  19, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{"sw_ack16",T_SW,   6'b000000, 1'b0, 16, 19, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"op101010",6'b101010, 6'b000000, 1'b0, 0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"r_fn0111",T_R,    6'b110111, 1'b0, 0,  2,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"lb_ack1", T_LB,   6'b000000, 1'b0, 1,  5,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{"lui",     T_LUI,  6'b000000, 1'b0, 0,  4,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        Rst_n = 1'b0;
        bus.Instr = mk(T_SW, 6'h0); bus.ALU_zero = 1'b1; bus.MEM_Ack = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("reset outputs", 32'(sample()), 32'd0);
        bus.MEM_Ack = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("idle after release", 32'(sample()), 32'd0);

        run_model("add", mk(T_R, 6'b110000), 1'b0, 0, 1'b0);
        run_model("lw3", mk(T_LW, 6'h0), 1'b0, 3, 1'b0);
        run_model("sb", mk(T_SB, 6'h0), 1'b0, 1, 1'b0);
        run_model("sw_tmo", mk(T_SW, 6'h0), 1'b0, 0, 1'b0);
        run_model("sw_ack16", mk(T_SW, 6'h0), 1'b0, 16, 1'b0);
        run_model("add_spurious_ack", mk(T_R, 6'b110001), 1'b0, 0, 1'b1);

        foreach (tbl[i]) begin
            measure(mk(tbl[i].op, tbl[i].fn), tbl[i].zero, tbl[i].ack_at, cyc, reqs, any, pcl);
            check({tbl[i].name, " latency"}, 32'(cyc), 32'(tbl[i].cycles));
            check({tbl[i].name, " req_cycles"}, 32'(reqs), 32'(tbl[i].reqs));
            check({tbl[i].name, " pc_sel"}, 32'(pcl), 32'(tbl[i].pcsel));
            check({tbl[i].name, " rf_wren"}, 32'(any.rfwr), 32'(tbl[i].rfwr));
            check({tbl[i].name, " wrdata_sel"}, 32'(any.wrsel), 32'(tbl[i].wrsel));
            check({tbl[i].name, " mem_wren"}, 32'(any.wren), 32'(tbl[i].wren));
            check({tbl[i].name, " byte_op"}, 32'(any.byte_), 32'(tbl[i].byte_));
            check({tbl[i].name, " illegal_op"}, 32'(any.ill), 32'(tbl[i].ill));
            check({tbl[i].name, " mem_err"}, 32'(any.merr), 32'(tbl[i].merr));
        end

        // Reset asserted while a store is waiting in MEM.
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            bus.Instr = mk(T_SW, 6'h0); bus.ALU_zero = 1'b0; bus.MEM_Ack = 1'b0;
        end
        #1;
        check("midmem req high", 32'(bus.MEM_Req), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("midmem reset outputs", 32'(sample()), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("midmem idle after release", 32'(sample()), 32'd0);

        ops = '{T_BEQ, T_BNE, T_LB, T_SB, T_LW, T_SW, T_ADDI, T_ANDI, T_ORI,
                T_LI, T_LUI, T_B, T_R, T_R, 6'b010101};
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom();
            op  = ops[$urandom_range(0, 14)];
            if (n % 7 == 6) op = rnd[31:26];
            run_model("rand", {op, rnd[25:6], 2'b11, rnd[3:0]}, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
